if_stage: RTL
=============

# if_stage

Instruction-fetch and program-counter stage of the MIPS core. Owns the PC register, issues word fetches to instruction memory over a req/ack handshake, holds the fetched instruction for the decoder, and computes the next PC from the `NPCOp` code the control unit returns. Sits directly upstream of `ctrl`: drives its `opcode`/`funct`/`rt` fields and `nop`, and consumes its `NPCOp`.

## Interface
- `RESET_PC`, 32'h0000_3000, PC loaded on reset.
- `EXC_VECTOR`, 32'h0000_4180, target for `NPC_EXCEPT` and misaligned-target exceptions.
- `clk`  in  1  clock, all state on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `NPCOp`  in  3  next-PC select from `ctrl` (`NPC_PLUS4`, `NPC_BRANCH`, `NPC_JUMP`, `NPC_JR`, `NPC_EXCEPT` from `ctrl_encode_def.v`).
- `rs_data`  in  32  GPR[rs], JR target.
- `stall`  in  1  hold current instruction in EXEC.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch word address (= `pc`).
- `imem_ack`  in  1  fetch data valid this cycle.
- `imem_rdata`  in  32  fetched word.
- `instr`  out  32  held instruction (to `ctrl` and datapath).
- `pc`  out  32  address of `instr`.
- `pc_plus4`  out  32  `pc`+4 (jal link value, `WDSel_FromPC`).
- `nop`  out  1  no valid instruction in `instr`.
- `epc`  out  32  PC of last excepting instruction.
- `exc_flag`  out  1  one-cycle exception pulse.

## Operation
- FSM states: IDLE, FETCH, EXEC.
- IDLE: entered on reset; `imem_req`=0, `nop`=1; unconditionally -> FETCH next cycle.
- FETCH: `imem_req`=1, `imem_addr`=`pc`, `nop`=1. On edge with `imem_ack`=1: `instr`<=`imem_rdata`, -> EXEC. Otherwise remain; `imem_addr` stable. `stall` ignored.
- EXEC: `imem_req`=0, `nop`=0; `ctrl` decodes `instr` combinationally. On edge with `stall`=0: `pc`<=next, -> FETCH. With `stall`=1: all state held.
- Next PC (combinational from `NPCOp`):
  - `NPC_PLUS4`: `pc`+4.
  - `NPC_BRANCH`: `pc`+4 + (sign_extend(`instr[15:0]`)<<2).
  - `NPC_JUMP`: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - `NPC_JR`: `rs_data`.
  - `NPC_EXCEPT`: `EXC_VECTOR`.
  - any other encoding: `pc`+4.
- All adds 32-bit modulo 2^32; wrap at 32'hFFFF_FFFC -> 32'h0 is silent.
- Exception on EXEC commit when `NPCOp`=`NPC_EXCEPT`, or computed target[1:0]!=0: `pc`<=`EXC_VECTOR`, `epc`<=`pc`, `exc_flag`=1 next cycle only.
- `imem_ack` outside FETCH ignored; `imem_rdata` never captured outside FETCH.

## Timing
- Reset values: `pc`=`RESET_PC`, `instr`=0, `nop`=1, `imem_req`=0, `epc`=0, `exc_flag`=0, state IDLE. Apply immediately on `rstn` falling, independent of `clk`.
- Reset mid-FETCH: request dropped asynchronously; a late `imem_ack` after release during IDLE is ignored.
- Fetch latency: `imem_req` rises 1 cycle after `rstn` release; with `imem_ack` same cycle as `imem_req`, minimum 2 cycles per instruction (FETCH, EXEC).
- `imem_addr`/`imem_req` are registered-state decodes; held stable until ack.
- `instr`, `pc`, `pc_plus4` stable throughout EXEC including stall.
- `exc_flag` asserts in the FETCH cycle following the excepting commit, same cycle `imem_addr`=`EXC_VECTOR`.
- `stall` and exception same cycle: stall wins; exception taken on first unstalled edge.

## Test plan
- Reset, release, `imem_ack` tied 1, `NPCOp`=`NPC_PLUS4` -> `imem_addr` 0x3000, 0x3004, 0x3008 on alternate cycles; `nop` toggles 1/0.
- `instr`=0x1000_FFFF at `pc`=0x3008, `NPCOp`=`NPC_BRANCH` -> next `imem_addr`=0x3008.
- `instr`=0x0C00_0C10 at `pc`=0x3000, `NPCOp`=`NPC_JUMP` -> `pc_plus4`=0x3004 in EXEC, next `imem_addr`=0x0000_3040.
- `NPCOp`=`NPC_JR`, `rs_data`=0x3101 at `pc`=0x3010 -> `imem_addr`=0x4180, `epc`=0x3010, `exc_flag` high exactly 1 cycle; `rs_data`=0x3100 -> `imem_addr`=0x3100, no exception.
- `imem_ack` delayed 3 cycles, then `stall`=1 for 2 EXEC cycles -> `imem_addr` constant during wait, `instr`/`pc` constant during stall, advance only after `stall`=0.
- `rstn` low mid-FETCH at `pc`=0x3020 -> `imem_req`=0 and `pc`=0x3000 same cycle; ack during IDLE ignored; first fetch after release at 0x3000.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch and program-counter stage.
// Owns the PC, fetches one word per instruction over a req/ack handshake,
// holds the fetched word for decode and selects the next PC from NPCOp.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | one cycle after reset, no request, no valid instruction
//   S_FETCH | request word at pc, wait for imem_ack
//   S_EXEC  | instr valid for ctrl, commit next pc on unstalled edge
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  NPCOp,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        nop,
  output logic [31:0] epc,
  output logic        exc_flag
);

  // Next-PC select codes shared with ctrl.
  localparam logic [2:0] NPC_PLUS4  = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JR     = 3'd3;
  localparam logic [2:0] NPC_EXCEPT = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] epc_q, epc_d;
  logic        exc_q, exc_d;

  logic [31:0] pc_plus4_w;
  logic [31:0] br_offset_w;
  logic [31:0] target_w;
  logic        take_exc_w;

  assign pc_plus4_w  = pc_q + 32'd4;
  assign br_offset_w = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Target selection; unknown codes fall back to sequential flow.
  always_comb begin
    target_w = pc_plus4_w;
    unique case (NPCOp)
      NPC_PLUS4:  target_w = pc_plus4_w;
      NPC_BRANCH: target_w = pc_plus4_w + br_offset_w;
      NPC_JUMP:   target_w = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
      NPC_JR:     target_w = rs_data;
      NPC_EXCEPT: target_w = EXC_VECTOR;
      default:    target_w = pc_plus4_w;
    endcase
  end

  // A misaligned target is redirected to the exception vector as well.
  assign take_exc_w = (NPCOp == NPC_EXCEPT) || (target_w[1:0] != 2'b00);

  // Next-state logic; exc_d defaults low so the flag is a single-cycle pulse.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    epc_d   = epc_q;
    exc_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Stall freezes everything, including a pending exception.
        if (!stall) begin
          state_d = S_FETCH;
          if (take_exc_w) begin
            pc_d  = EXC_VECTOR;
            epc_d = pc_q;
            exc_d = 1'b1;
          end else begin
            pc_d = target_w;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers, cleared asynchronously so a pending request drops at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      epc_q   <= 32'h0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      epc_q   <= epc_d;
      exc_q   <= exc_d;
    end
  end

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign nop       = (state_q != S_EXEC);
  assign instr     = instr_q;
  assign pc        = pc_q;
  assign pc_plus4  = pc_plus4_w;
  assign epc       = epc_q;
  assign exc_flag  = exc_q;

endmodule
